// File: rtl/tt_um_tdm_demux.sv
// Two-channel TDM demultiplexer: hunts for fsync, deserializes 8-slot frames,
// and updates both 4-bit channel words together when slot 7 arrives.
module tt_um_tdm_demux (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  sr_q, sr_d;
    logic [7:0]  out_q, out_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        err_set;

    logic sdata, fsync, strobe, clr_err, bit_ev;
    logic unused_inputs;

    assign sdata         = ui_in[0];
    assign fsync         = ui_in[1];
    assign strobe        = ui_in[2];
    assign clr_err       = ui_in[3];
    assign bit_ev        = ena & strobe;
    assign unused_inputs = ^{uio_in, ui_in[7:4]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_set = 1'b0;
        if (bit_ev) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        sr_d    = {6'b0, sdata};
                        cnt_d   = 3'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fsync) begin
                        // fsync anywhere but slot 0 drops the partial frame and restarts
                        if (cnt_q != 3'd0) err_set = 1'b1;
                        sr_d  = {6'b0, sdata};
                        cnt_d = 3'd1;
                    end else if (cnt_q == 3'd0) begin
                        err_set = 1'b1;
                        state_d = HUNT;
                    end else if (cnt_q == 3'd7) begin
                        // sr_q[6:3] holds slots 0-3 (A), {sr_q[2:0], sdata} slots 4-7 (B)
                        out_d  = {sr_q[2:0], sdata, sr_q[6:3]};
                        done_d = 1'b1;
                        cnt_d  = 3'd0;
                    end else begin
                        sr_d  = {sr_q[5:0], sdata};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (err_set)      err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
        else              err_d = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            sr_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign uo_out  = out_q;
    assign uio_out = {4'b0, (state_q == LOCKED) & cnt_q[2], err_q,
                      state_q == LOCKED, done_q};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_tdm_demux.sv
// Randomized scoreboard bench for tt_um_tdm_demux against a slot-list reference model.
module tb_tt_um_tdm_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_tdm_demux dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model: the slots received so far in the current frame, in order.
    bit         m_hunt = 1'b1;
    bit         m_bits[$];
    bit         m_err = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] m_out = '0;
    logic [7:0] exp_q[$];

    int passed = 0;
    int total  = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    task automatic model_edge(input bit sd, input bit fs, input bit st,
                              input bit en, input bit clr);
        bit seterr;
        logic [3:0] a, b;
        seterr = 1'b0;
        m_done = 1'b0;
        if (en && st) begin
            if (m_hunt) begin
                if (fs) begin
                    m_bits = '{sd};
                    m_hunt = 1'b0;
                end
            end else if (m_bits.size() == 0) begin
                if (fs) m_bits = '{sd};
                else begin
                    seterr = 1'b1;
                    m_hunt = 1'b1;
                end
            end else if (fs) begin
                seterr = 1'b1;
                m_bits = '{sd};
            end else begin
                m_bits.push_back(sd);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 4; i++) begin
                        a[3-i] = m_bits[i];
                        b[3-i] = m_bits[4+i];
                    end
                    m_out = {b, a};
                    exp_q.push_back({b, a});
                    m_done = 1'b1;
                    m_bits.delete();
                end
            end
        end
        if (seterr)   m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic step(input bit sd, input bit fs, input bit st,
                        input bit en, input bit clr);
        ui_in = {4'b0, clr, st, fs, sd};
        ena   = en;
        @(posedge clk);
        model_edge(sd, fs, st, en, clr);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] slots, input int gap);
        for (int i = 0; i < 8; i++) begin
            repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(slots[7-i], i == 0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        m_hunt = 1'b1;
        m_bits.delete();
        m_err  = 1'b0;
        m_done = 1'b0;
        m_out  = '0;
        #1;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h0F);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: status compared every cycle, frame words popped on frame_done.
    always @(negedge clk) begin
        if (rst_n) begin
            check("locked", uio_out[1], !m_hunt);
            check("sel", uio_out[3], !m_hunt && m_bits.size() >= 4);
            check("sync_err", uio_out[2], m_err);
            check("frame_done", uio_out[0], m_done);
            check("uio_out_hi", uio_out[7:4], 4'h0);
            check("uo_out_hold", uo_out, m_out);
            if (uio_out[0]) begin
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("uo_out_frame", uo_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        int tpos;
        bit fs, st, en, clr, sd;

        #12;
        check("init_uo_out", uo_out, 8'h00);
        check("init_uio_out", uio_out, 8'h00);
        check("init_uio_oe", uio_oe, 8'h0F);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-frame, then fsync-less events must not lock
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        do_reset();
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_reset_unlocked", uio_out[1], 1'b0);

        // Nominal frame
        send_frame(8'hA5, 0);
        check("nominal_uo", uo_out, 8'h5A);
        check("nominal_done", uio_out[0], 1'b1);

        // Gapped strobes with an ena=0 pause mid-frame
        for (int i = 0; i < 8; i++) begin
            repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 4) repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            step(((8'hA5 >> (7 - i)) & 8'h01) != 0, i == 0, 1'b1, 1'b1, 1'b0);
        end
        check("gapped_uo", uo_out, 8'h5A);

        // Missing sync at slot 0
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("missing_sync_err", uio_out[2:1], 2'b10);
        check("missing_sync_uo", uo_out, 8'h5A);

        // clr_err alone while disabled
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_err_ena0", uio_out[2], 1'b0);

        // Early sync at slot 5, new frame A=3, B=C
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 0);
        check("early_sync_uo", uo_out, 8'hC3);
        check("early_sync_status", uio_out[2:1], 2'b11);

        // clr_err on the same edge as a new error: set wins
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_err_plain", uio_out[2], 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_vs_set", uio_out[2], 1'b1);

        // Randomized traffic with occasional sync corruption
        tpos = 0;
        for (int n = 0; n < 3000; n++) begin
            st  = ($urandom % 4) != 0;
            en  = ($urandom % 16) != 0;
            clr = ($urandom % 32) == 0;
            sd  = $urandom % 2;
            fs  = (tpos == 0);
            if (($urandom % 40) == 0) fs = !fs;
            step(sd, fs, st, en, clr);
            if (st && en) tpos = (tpos + 1) % 8;
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tt_um_tdm_demux.md
# tt_um_tdm_demux

Two-channel time-division demultiplexer, the receiving end of a serial link whose transmitter uses a select-driven 2:1 mux to interleave two 4-bit channels onto one wire. It hunts for frame sync, deserializes 8-slot frames, and updates both channel outputs together at the end of each frame. Error status and the current channel slot are reported on the bidirectional pins. It sits as a standard Tiny Tapeout user-project top.

## Interface
Parameters:
- none. The format is fixed: 8-slot frame, 2 channels × 4 bits.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  design enable; 0 makes every bit event be ignored.
- `ui_in`  in  8  inputs:
  - [0] sdata, serial data.
  - [1] fsync, marks slot 0.
  - [2] strobe, bit valid.
  - [3] clr_err.
  - [7:4] ignored.
- `uio_in`  in  8  ignored.
- `uo_out`  out  8  outputs:
  - [3:0] channel A word.
  - [7:4] channel B word.
- `uio_out`  out  8  outputs:
  - [0] frame_done.
  - [1] locked.
  - [2] sync_err.
  - [3] sel.
  - [7:4] always 0.
- `uio_oe`  out  8  constant 8'h0F.

## Operation
- Bit event: rising edge where ena=1 and strobe=1. Only bit events advance the framing logic.
- State:
  - FSM: HUNT or LOCKED.
  - 3-bit slot counter `cnt`.
  - 7-bit shift register `sr`.
- Slot mapping:
  - Slots 0–3 are channel A, MSB first (slot 0 → A[3]).
  - Slots 4–7 are channel B, MSB first (slot 4 → B[3]).
- HUNT:
  - Bit event with fsync=0: ignored.
  - Bit event with fsync=1: sdata becomes slot 0, cnt←1, go to LOCKED.
- LOCKED, on a bit event:
  - cnt=0 and fsync=1: normal frame start; sdata becomes slot 0, cnt←1.
  - cnt=0 and fsync=0: set sync_err, go to HUNT. No output update.
  - cnt∈1..7 and fsync=1: early sync. Set sync_err, discard the partial frame, sdata becomes slot 0, cnt←1, stay LOCKED.
  - cnt∈1..6 and fsync=0: shift sdata in, cnt←cnt+1.
  - cnt=7 and fsync=0: the frame is complete.
    - uo_out ← {B, A}, built from sr plus the current sdata.
    - frame_done←1.
    - cnt wraps to 0.
- frame_done: high for exactly one cycle after each completed frame; low otherwise.
- locked = (state==LOCKED).
- sel:
  - In LOCKED: cnt[2], i.e. the channel of the next expected slot.
  - In HUNT: 0.
- sync_err: sticky.
  - Cleared on any edge with clr_err=1; clearing does not depend on ena.
  - If an error is set and clr_err=1 on the same edge, set wins.
- uo_out holds its last completed frame until the next completed frame. It is never updated by partial or errored frames.
- ena=0: FSM, cnt and sr hold, frame_done is 0, clr_err still acts.
- Reset (rst_n=0, any time, including mid-frame):
  - State HUNT, cnt=0, sr=0.
  - uo_out=0, uio_out[3:0]=0.
  - uio_oe stays 8'h0F, uio_out[7:4] stays 0.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: uo_out and frame_done change on the same rising edge that samples slot 7 and are visible for that following cycle.
- Bit events may occur on consecutive cycles (one bit per clk, maximum rate) or with arbitrary gaps. Non-event cycles have no effect.
- locked and sel update on the edge of the causing bit event.
- Reset release: the first edge with rst_n=1 can already be a bit event.

## Test plan
- Reset mid-frame:
  - Stimulus: lock and shift 3 slots, then pulse rst_n low.
  - Response: uo_out=0x00, uio_out=0x00, uio_oe=0x0F immediately, without waiting for a clk edge.
  - Afterwards: fsync=0 bit events are ignored (locked stays 0).
- Nominal frame:
  - Stimulus: ena=1, strobe=1 every cycle, sdata slots 1,0,1,0,0,1,0,1, fsync=1 on slot 0 only.
  - Response: after the 8th edge, uo_out=0x5A (A=0xA, B=0x5) and frame_done=1 for one cycle.
  - Status: locked=1; sel reads 0,0,0,1,1,1,1,0 after each of edges 1–8.
- Gapped strobes:
  - Stimulus: the same frame with strobe every 3rd cycle, and ena=0 for 2 cycles mid-frame.
  - Response: identical uo_out=0x5A, exactly one frame_done pulse, no early update.
- Missing sync:
  - Stimulus: after a good 0x5A frame, next slot-0 event has fsync=0.
  - Response: sync_err=1, locked=0, uo_out stays 0x5A, no frame_done.
- Early sync:
  - Stimulus: fsync=1 at slot 5, then 7 more events carrying A=0x3, B=0xC.
  - Response: sync_err=1, locked stays 1, a single frame_done, uo_out=0xC3.
- Error clear:
  - Stimulus 1: clr_err=1 on the same edge as a new sync error → sync_err remains 1.
  - Stimulus 2: clr_err=1 alone, with ena=0 → sync_err=0 on the next edge.
